// File: rtl/univ_shift_register_n.sv
// Parametrised universal shift register with shift/rotate/load/clear modes
// and frame tracking that pulses once every WIDTH shift operations.
module univ_shift_register_n #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rs,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic                     sin_lsb,
    input  logic                     sin_msb,
    input  logic [WIDTH-1:0]         PI,
    output logic [WIDTH-1:0]         PO,
    output logic                     sout_msb,
    output logic                     sout_lsb,
    output logic [$clog2(WIDTH)-1:0] shift_cnt,
    output logic                     frame_done,
    output logic [WIDTH-1:0]         frame_word
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SL   = 3'b001;
    localparam logic [2:0] M_SR   = 3'b010;
    localparam logic [2:0] M_RL   = 3'b011;
    localparam logic [2:0] M_RR   = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_LOAD = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic [WIDTH-1:0] next_po;
    logic             is_shift;

    always_comb begin
        next_po  = PO;
        is_shift = 1'b0;
        unique case (mode)
            M_HOLD: next_po = PO;
            M_SL: begin
                next_po  = {PO[WIDTH-2:0], sin_lsb};
                is_shift = 1'b1;
            end
            M_SR: begin
                next_po  = {sin_msb, PO[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_RL: begin
                next_po  = {PO[WIDTH-2:0], PO[WIDTH-1]};
                is_shift = 1'b1;
            end
            M_RR: begin
                next_po  = {PO[0], PO[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_ASR: begin
                next_po  = {PO[WIDTH-1], PO[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_LOAD: next_po = PI;
            M_CLR:  next_po = '0;
            default: next_po = PO;
        endcase
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            PO         <= '0;
            shift_cnt  <= '0;
            frame_done <= 1'b0;
            frame_word <= '0;
        end else begin
            frame_done <= 1'b0;
            if (en) begin
                PO <= next_po;
                if (is_shift) begin
                    if (shift_cnt == LAST) begin
                        shift_cnt  <= '0;
                        frame_done <= 1'b1;
                        frame_word <= next_po;
                    end else begin
                        shift_cnt <= shift_cnt + 1'b1;
                    end
                end else if (mode == M_LOAD || mode == M_CLR) begin
                    // a load or clear abandons the frame without a pulse
                    shift_cnt <= '0;
                end
            end
        end
    end

    assign sout_msb = PO[WIDTH-1];
    assign sout_lsb = PO[0];

endmodule

// File: tb/tb_univ_shift_register_n.sv
// Bench for univ_shift_register_n: WIDTH=8 and WIDTH=4 instances checked
// against an arithmetic frame model every cycle plus literal expectations.
module tb_univ_shift_register_n;

    logic       clk = 1'b0;
    logic       rs = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'b000;
    logic       sin_lsb = 1'b0;
    logic       sin_msb = 1'b0;
    logic [7:0] pi = 8'h00;

    logic [7:0] po8, fw8;
    logic [2:0] cnt8;
    logic       smsb8, slsb8, fd8;
    logic [3:0] po4, fw4;
    logic [1:0] cnt4;
    logic       smsb4, slsb4, fd4;

    int passed = 0;
    int total = 0;
    bit chk_on = 0;

    int wd[2] = '{8, 4};
    int mpo[2];
    int mcnt[2];
    int mfw[2];
    int mfd[2];

    always #5 clk = ~clk;

    univ_shift_register_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rs(rs), .en(en), .mode(mode),
        .sin_lsb(sin_lsb), .sin_msb(sin_msb), .PI(pi),
        .PO(po8), .sout_msb(smsb8), .sout_lsb(slsb8),
        .shift_cnt(cnt8), .frame_done(fd8), .frame_word(fw8)
    );

    univ_shift_register_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rs(rs), .en(en), .mode(mode),
        .sin_lsb(sin_lsb), .sin_msb(sin_msb), .PI(pi[3:0]),
        .PO(po4), .sout_msb(smsb4), .sout_lsb(slsb4),
        .shift_cnt(cnt4), .frame_done(fd4), .frame_word(fw4)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mpo[i] = 0; mcnt[i] = 0; mfw[i] = 0; mfd[i] = 0;
        end
    endtask

    // Arithmetic view of each mode: shifts are multiply/divide by two.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int w, half, full, p, nxt;
            bit sh;
            w = wd[i]; half = 1 << (w - 1); full = 1 << w;
            p = mpo[i]; nxt = p; sh = 0;
            mfd[i] = 0;
            if (en) begin
                case (mode)
                    3'd1: begin nxt = (p * 2 + sin_lsb) % full; sh = 1; end
                    3'd2: begin nxt = p / 2 + (sin_msb ? half : 0); sh = 1; end
                    3'd3: begin nxt = (p * 2) % full + p / half; sh = 1; end
                    3'd4: begin nxt = p / 2 + (p % 2) * half; sh = 1; end
                    3'd5: begin nxt = p / 2 + (p >= half ? half : 0); sh = 1; end
                    3'd6: begin nxt = pi % full; mcnt[i] = 0; end
                    3'd7: begin nxt = 0; mcnt[i] = 0; end
                    default: nxt = p;
                endcase
                mpo[i] = nxt;
                if (sh) begin
                    mcnt[i]++;
                    if (mcnt[i] == w) begin
                        mcnt[i] = 0; mfd[i] = 1; mfw[i] = nxt;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("po8", po8, mpo[0]);
            check("sout_msb8", smsb8, mpo[0] / 128);
            check("sout_lsb8", slsb8, mpo[0] % 2);
            check("cnt8", cnt8, mcnt[0]);
            check("fd8", fd8, mfd[0]);
            check("fw8", fw8, mfw[0]);
            check("po4", po4, mpo[1]);
            check("sout_msb4", smsb4, mpo[1] / 8);
            check("sout_lsb4", slsb4, mpo[1] % 2);
            check("cnt4", cnt4, mcnt[1]);
            check("fd4", fd4, mfd[1]);
            check("fw4", fw4, mfw[1]);
        end
    end

    task automatic step(input logic e, input logic [2:0] m,
                        input logic sl, input logic sm, input logic [7:0] d);
        en = e; mode = m; sin_lsb = sl; sin_msb = sm; pi = d;
        @(posedge clk);
        model_update();
        #2;
    endtask

    logic [7:0] bits_e9 = 8'b1110_1001;

    initial begin
        model_reset();
        #1 rs = 1'b1;
        #1;
        check("rst_po", po8, 8'h00);
        check("rst_cnt", cnt8, 0);
        check("rst_fd", fd8, 0);
        check("rst_fw", fw8, 8'h00);
        #1 rs = 1'b0;
        chk_on = 1;

        for (int i = 7; i >= 0; i--) begin
            step(1, 3'd1, bits_e9[i], 0, 8'h00);
            if (i == 4) begin
                check("w4_fd", fd4, 1);
                check("w4_fw", fw4, 4'hE);
            end
            if (i == 1) check("sl_fd_early", fd8, 0);
        end
        check("sl_po", po8, 8'hE9);
        check("sl_fd", fd8, 1);
        check("sl_fw", fw8, 8'hE9);
        check("sl_cnt", cnt8, 0);
        step(1, 3'd0, 0, 0, 8'h00);
        check("fd_pulse_end", fd8, 0);

        step(1, 3'd6, 0, 0, 8'hA5);
        step(1, 3'd3, 0, 0, 8'h00);
        check("rl1", po8, 8'h4B);
        step(1, 3'd3, 0, 0, 8'h00);
        check("rl2", po8, 8'h96);
        check("rl_cnt", cnt8, 2);
        step(1, 3'd3, 0, 0, 8'h00);
        check("rl_cnt3", cnt8, 3);
        step(1, 3'd6, 0, 0, 8'hA5);
        check("ld_cnt", cnt8, 0);
        check("ld_fd", fd8, 0);
        step(1, 3'd4, 0, 0, 8'h00);
        check("rr", po8, 8'hD2);
        check("rr_cnt", cnt8, 1);

        step(1, 3'd6, 0, 0, 8'h90);
        step(1, 3'd5, 0, 0, 8'h00);
        check("asr1", po8, 8'hC8);
        step(1, 3'd5, 0, 0, 8'h00);
        check("asr2", po8, 8'hE4);
        step(1, 3'd6, 0, 0, 8'h90);
        step(1, 3'd2, 0, 0, 8'h00);
        check("lsr", po8, 8'h48);
        step(1, 3'd2, 0, 1, 8'h00);
        check("lsr_sin1", po8, 8'hA4);

        step(1, 3'd7, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 3'd1, 1, 0, 8'h00);
        rs = 1'b1;
        #1;
        check("arst_po", po8, 8'h00);
        check("arst_cnt", cnt8, 0);
        model_reset();
        #1 rs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1, (i % 2 == 0) ? 3'd1 : 3'd3, 1, 0, 8'h00);
            if (i == 6) check("arst_fd7", fd8, 0);
        end
        check("arst_fd8", fd8, 1);

        step(1, 3'd6, 0, 0, 8'h3C);
        step(1, 3'd1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 3'(i * 2 + 1), 1, 1, 8'hFF);
        check("en0_po", po8, 8'h78);
        check("en0_cnt", cnt8, 1);
        check("en0_fd", fd8, 0);

        for (int i = 0; i < 10; i++) step(1, 3'(1 + i % 5), i % 2, 1, 8'h00);
        step(1, 3'd0, 0, 0, 8'h00);

        chk_on = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
